gray_sobel_edge: RTL

- Downstream of the RGB-to-gray stage. Consumes its 8-bit luma pixel stream (one replicated byte of the 24-bit gray bus) plus its enable.
- Runs a 3x3 Sobel operator using two line buffers and produces a saturated gradient magnitude plus a thresholded edge bit per interior pixel.
- Feeds the plate-localisation stages.

---
 rtl/gray_sobel_edge_pkg.sv | 14 +
 rtl/gray_sobel_edge_if.sv | 23 ++
 rtl/gray_sobel_edge_line_buffer.sv | 22 ++
 rtl/gray_sobel_edge.sv | 130 +++++++++++++
 4 files changed

// File: rtl/gray_sobel_edge_pkg.sv
// Shared widths, constants and helpers for the Sobel edge stage.
package gray_sobel_pkg;
  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int SUM_W  = 12;

  localparam logic [PIX_W-1:0] MAG_MAX = 8'd255;
  localparam logic [PIX_W-1:0] THR_RST = 8'd128;

  // Magnitude of a signed gradient; -1024 cannot occur (|G| <= 1020).
  function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
  endfunction
endpackage

// File: rtl/gray_sobel_edge_if.sv
// Pixel-in / edge-out stream bundle between the gray stage, the Sobel stage and its consumer.
interface gray_sobel_edge_if;
  import gray_sobel_pkg::*;

  logic [PIX_W-1:0] gray_in;
  logic             gray_valid;
  logic             sof;
  logic [PIX_W-1:0] threshold;
  logic [PIX_W-1:0] edge_mag;
  logic             edge_bit;
  logic             out_valid;
  logic             frame_done;

  modport master (
    output gray_in, gray_valid, sof, threshold,
    input  edge_mag, edge_bit, out_valid, frame_done
  );

  modport slave (
    input  gray_in, gray_valid, sof, threshold,
    output edge_mag, edge_bit, out_valid, frame_done
  );
endinterface

// File: rtl/gray_sobel_edge_line_buffer.sv
// Single-port line buffer: asynchronous read of the addressed word, write on the same
// edge, so the old contents are available to the caller before they are overwritten.
module sobel_line_buffer #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Storage is intentionally not reset; the row counter gates its use.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/gray_sobel_edge.sv
// 3x3 Sobel edge stage: two line buffers feed a shifting window, then gradient,
// |Gx|+|Gy| and saturate/threshold stages. Output follows the accepting edge by 3 clk.
module gray_sobel_edge
  import gray_sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 10
) (
  input logic               clk,
  input logic               rst_n,
  gray_sobel_edge_if.slave  io
);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

  logic [CNT_W-1:0] col, row;
  logic [CNT_W-1:0] pix_col, pix_row;
  logic             accept, last_pix, qualify;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] thr_q;
  logic [PIX_W-1:0] win [3][3];
  logic             v1, v2, v3;
  logic [GRAD_W-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [GRAD_W-1:0] gx_q, gy_q;
  logic [SUM_W-1:0] sum_q;
  logic [PIX_W-1:0] mag_c;
  logic [PIX_W-1:0] edge_mag_q;
  logic             edge_bit_q, out_valid_q, frame_done_q;

  // An accepted sof pixel sits at (0,0) regardless of where counting had reached.
  assign accept   = io.gray_valid;
  assign pix_col  = io.sof ? '0 : col;
  assign pix_row  = io.sof ? '0 : row;
  assign last_pix = (pix_col == COL_LAST) && (pix_row == ROW_LAST);
  assign qualify  = accept && (pix_row >= CNT_W'(2)) && (pix_col >= CNT_W'(2));

  // Raster position counters, frame-end pulse and per-frame threshold latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      frame_done_q <= 1'b0;
      thr_q        <= THR_RST;
    end else begin
      frame_done_q <= accept && last_pix;
      if (accept) begin
        if (io.sof) thr_q <= io.threshold;
        if (pix_col == COL_LAST) begin
          col <= '0;
          row <= (pix_row == ROW_LAST) ? '0 : pix_row + CNT_W'(1);
        end else begin
          col <= pix_col + CNT_W'(1);
          row <= pix_row;
        end
      end
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .ADDR_W(CNT_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (pix_col),
    .wdata (io.gray_in),
    .rdata (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .ADDR_W(CNT_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (pix_col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Window shifts left on each accept; new right column is rows r-2, r-1, r.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_rd;
      win[1][2] <= lb0_rd;
      win[2][2] <= io.gray_in;
    end
  end

  assign gx_pos = GRAD_W'(win[0][2]) + (GRAD_W'(win[1][2]) << 1) + GRAD_W'(win[2][2]);
  assign gx_neg = GRAD_W'(win[0][0]) + (GRAD_W'(win[1][0]) << 1) + GRAD_W'(win[2][0]);
  assign gy_pos = GRAD_W'(win[2][0]) + (GRAD_W'(win[2][1]) << 1) + GRAD_W'(win[2][2]);
  assign gy_neg = GRAD_W'(win[0][0]) + (GRAD_W'(win[0][1]) << 1) + GRAD_W'(win[0][2]);

  assign mag_c = (sum_q > SUM_W'(MAG_MAX)) ? MAG_MAX : sum_q[PIX_W-1:0];

  // Valid bits march every cycle so launched work drains across input gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      out_valid_q <= 1'b0;
      edge_mag_q  <= '0;
      edge_bit_q  <= 1'b0;
    end else begin
      v1          <= qualify;
      v2          <= v1;
      v3          <= v2;
      out_valid_q <= v3;
      if (v3) begin
        edge_mag_q <= mag_c;
        edge_bit_q <= (mag_c >= thr_q);
      end
    end
  end

  // Gradient and magnitude datapath registers, loaded only when their stage is live.
  always_ff @(posedge clk) begin
    if (v1) begin
      gx_q <= signed'(gx_pos - gx_neg);
      gy_q <= signed'(gy_pos - gy_neg);
    end
    if (v2) sum_q <= SUM_W'(abs_grad(gx_q)) + SUM_W'(abs_grad(gy_q));
  end

  assign io.edge_mag   = edge_mag_q;
  assign io.edge_bit   = edge_bit_q;
  assign io.out_valid  = out_valid_q;
  assign io.frame_done = frame_done_q;
endmodule
